// File: rtl/versatile_fifo_rd_ctrl.sv
// Read-side controller for the async dual-clock FIFO: owns the read pointer and serves words through a
// 2-entry first-word-fall-through output buffer. Define FIFO_RD_WORDCNT_EN to add the rd_count port.
module versatile_fifo_rd_ctrl #(
   parameter int unsigned ADDR_WIDTH = 4,
   parameter int unsigned DATA_WIDTH = 8
) (
   input  logic                  rclk,
   input  logic                  rst,
   input  logic                  fifo_empty,
   output logic [ADDR_WIDTH-1:0] rptr,
   output logic [ADDR_WIDTH-1:0] ram_adr,
   output logic                  ram_rd_en,
   input  logic [DATA_WIDTH-1:0] ram_dat,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready
`ifdef FIFO_RD_WORDCNT_EN
   ,
   output logic [15:0]           rd_count
`endif
);

   typedef enum logic [1:0] {
      StEmpty = 2'd0,
      StOne   = 2'd1,
      StTwo   = 2'd2
   } occ_e;

   occ_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0] rbin_q, rbin_d;
   logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
   logic [DATA_WIDTH-1:0] dout_q, dout_d;
   logic [DATA_WIDTH-1:0] skid_q, skid_d;
   logic                  inflight_q, inflight_d;

   logic                  pop;
   logic                  capture;
   logic                  issue;
   logic [2:0]            pending;
   logic [ADDR_WIDTH-1:0] rbin_inc;

   assign pop     = (state_q != StEmpty) & dout_ready;
   assign capture = inflight_q;

   // Words held or arriving after this edge; pop implies occ >= 1 so this never underflows.
   assign pending = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
   assign issue   = ~rst & ~fifo_empty & (pending <= 3'd1);

   assign rbin_inc = rbin_q + ADDR_WIDTH'(1);

   always_comb begin
      rbin_d     = rbin_q;
      rptr_d     = rptr_q;
      inflight_d = issue;
      if (issue) begin
         rbin_d = rbin_inc;
         rptr_d = rbin_inc ^ (rbin_inc >> 1);
      end
   end

   always_comb begin
      state_d = state_q;
      dout_d  = dout_q;
      skid_d  = skid_q;
      unique case (state_q)
         StEmpty: begin
            if (capture) begin
               dout_d  = ram_dat;
               state_d = StOne;
            end
         end
         StOne: begin
            if (capture && pop) begin
               dout_d = ram_dat;
            end else if (capture) begin
               skid_d  = ram_dat;
               state_d = StTwo;
            end else if (pop) begin
               state_d = StEmpty;
            end
         end
         StTwo: begin
            if (pop) begin
               dout_d  = skid_q;
               state_d = StOne;
            end
         end
         default: state_d = StEmpty;
      endcase
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         state_q    <= StEmpty;
         rbin_q     <= '0;
         rptr_q     <= '0;
         dout_q     <= '0;
         skid_q     <= '0;
         inflight_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         rbin_q     <= rbin_d;
         rptr_q     <= rptr_d;
         dout_q     <= dout_d;
         skid_q     <= skid_d;
         inflight_q <= inflight_d;
      end
   end

   assign rptr       = rptr_q;
   assign ram_adr    = rbin_q;
   assign ram_rd_en  = issue;
   assign dout       = dout_q;
   assign dout_valid = (state_q != StEmpty);

`ifdef FIFO_RD_WORDCNT_EN
   logic [15:0] rd_count_q, rd_count_d;

   always_comb begin
      rd_count_d = rd_count_q;
      if (pop) begin
         rd_count_d = rd_count_q + 16'd1;
      end
   end

   always_ff @(posedge rclk) begin
      if (rst) begin
         rd_count_q <= '0;
      end else begin
         rd_count_q <= rd_count_d;
      end
   end

   assign rd_count = rd_count_q;
`endif

   // Issue throttling guarantees a full buffer never sees returning RAM data.
   capture_when_full: assert property (@(posedge rclk) disable iff (rst)
      !((state_q == StTwo) && capture));

endmodule

// File: tb/tb_versatile_fifo_rd_ctrl.sv
// Self-checking bench for versatile_fifo_rd_ctrl: RAM and write-side comparator model, scoreboard
// of written words, cycle table for the basic stream, and sequences for stall, wrap and reset.
module tb_versatile_fifo_rd_ctrl;
   localparam int unsigned AW = 4;
   localparam int unsigned DW = 8;

   logic          rclk       = 1'b0;
   logic          rst        = 1'b1;
   logic          hold_empty = 1'b1;
   logic          dout_ready = 1'b0;
   logic          fifo_empty;
   logic [AW-1:0] rptr;
   logic [AW-1:0] ram_adr;
   logic          ram_rd_en;
   logic [DW-1:0] ram_dat    = '0;
   logic [DW-1:0] dout;
   logic          dout_valid;
`ifdef FIFO_RD_WORDCNT_EN
   logic [15:0]   rd_count;
   logic [15:0]   m_count    = '0;
`endif

   logic [DW-1:0] mem [16];
   logic [AW-1:0] wbin = '0;
   logic [DW-1:0] exp_q [$];

   int checks   = 0;
   int failures = 0;

   logic          mon_en        = 1'b0;
   logic [AW-1:0] m_rbin        = '0;
   logic [AW-1:0] prev_rptr     = '0;
   logic [AW-1:0] last_adr      = '0;
   logic          prev_rst      = 1'b1;
   logic          last_adr_ok   = 1'b0;
   logic          saw_adr_wrap  = 1'b0;
   logic          saw_rptr_wrap = 1'b0;

   typedef struct {
      logic          ready;
      logic          rd_en;
      logic          valid;
      logic [DW-1:0] dout;
      logic [AW-1:0] rptr;
   } vec_t;

   vec_t t2 [7];

   versatile_fifo_rd_ctrl #(
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .rclk       (rclk),
      .rst        (rst),
      .fifo_empty (fifo_empty),
      .rptr       (rptr),
      .ram_adr    (ram_adr),
      .ram_rd_en  (ram_rd_en),
      .ram_dat    (ram_dat),
      .dout       (dout),
      .dout_valid (dout_valid),
      .dout_ready (dout_ready)
`ifdef FIFO_RD_WORDCNT_EN
      ,
      .rd_count   (rd_count)
`endif
   );

   always #5 rclk = ~rclk;

   function automatic logic [AW-1:0] gray(input logic [AW-1:0] b);
      return b ^ (b >> 1);
   endfunction

   assign fifo_empty = hold_empty | (gray(wbin) == rptr);

   always @(posedge rclk) begin
      if (ram_rd_en) ram_dat <= mem[ram_adr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic write_word(input logic [DW-1:0] d);
      mem[wbin] = d;
      wbin      = wbin + 4'd1;
      exp_q.push_back(d);
   endtask

   // Entered at a falling edge; leaves at a falling edge.
   task automatic do_reset();
      rst  = 1'b1;
      wbin = '0;
      exp_q.delete();
      @(posedge rclk);
      @(negedge rclk);
      rst = 1'b0;
      #1;
      check("rst_dout_valid", 32'(dout_valid), 0);
      check("rst_rptr", 32'(rptr), 0);
      check("rst_ram_adr", 32'(ram_adr), 0);
      check("rst_dout", 32'(dout), 0);
   endtask

   task automatic stream(input int n);
      int sent  = 0;
      int guard = 0;
      dout_ready = 1'b1;
      while ((sent < n || exp_q.size() != 0) && guard < 4 * n + 50) begin
         if (sent < n && exp_q.size() < 8) begin
            write_word(DW'($urandom));
            sent++;
         end
         @(posedge rclk);
         @(negedge rclk);
         guard++;
      end
      check("stream_drained", 32'(exp_q.size()), 0);
   endtask

   // Monitor: pointer model, Gray/single-step checks, reset gating and scoreboard pops.
   always @(negedge rclk) begin
      #2;
      if (mon_en) begin
         check("rptr_gray", 32'(rptr), 32'(gray(m_rbin)));
         if (!prev_rst) check("rptr_one_bit", 32'($countones(rptr ^ prev_rptr) <= 1), 1);
         if (!prev_rst && prev_rptr == 4'b1000 && rptr == 4'b0000) saw_rptr_wrap = 1'b1;
         if (rst) begin
            check("rd_en_in_rst", 32'(ram_rd_en), 0);
         end else if (ram_rd_en) begin
            check("ram_adr", 32'(ram_adr), 32'(m_rbin));
            if (last_adr_ok && last_adr == 4'd15 && ram_adr == 4'd0) saw_adr_wrap = 1'b1;
            last_adr    = ram_adr;
            last_adr_ok = 1'b1;
         end
         if (dout_valid && dout_ready && !rst) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL sb_extra_pop: got %0h expected no word", dout);
            end else begin
               check("sb_dout", 32'(dout), 32'(exp_q.pop_front()));
            end
         end
`ifdef FIFO_RD_WORDCNT_EN
         check("rd_count", 32'(rd_count), 32'(m_count));
         if (rst) m_count = '0;
         else if (dout_valid && dout_ready) m_count = m_count + 16'd1;
`endif
         if (rst) begin
            m_rbin      = '0;
            last_adr_ok = 1'b0;
         end else if (ram_rd_en) begin
            m_rbin = m_rbin + 4'd1;
         end
         prev_rptr = rptr;
         prev_rst  = rst;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [DW-1:0] first;
      int            n_rd;
      int            guard;

      t2[0] = '{ready: 1'b1, rd_en: 1'b1, valid: 1'b0, dout: 8'h00, rptr: 4'b0000};
      t2[1] = '{ready: 1'b1, rd_en: 1'b1, valid: 1'b0, dout: 8'h00, rptr: 4'b0001};
      t2[2] = '{ready: 1'b1, rd_en: 1'b1, valid: 1'b1, dout: 8'hA0, rptr: 4'b0011};
      t2[3] = '{ready: 1'b1, rd_en: 1'b1, valid: 1'b1, dout: 8'hA1, rptr: 4'b0010};
      t2[4] = '{ready: 1'b1, rd_en: 1'b0, valid: 1'b1, dout: 8'hA2, rptr: 4'b0110};
      t2[5] = '{ready: 1'b1, rd_en: 1'b0, valid: 1'b1, dout: 8'hA3, rptr: 4'b0110};
      t2[6] = '{ready: 1'b1, rd_en: 1'b0, valid: 1'b0, dout: 8'h00, rptr: 4'b0110};

      @(posedge rclk);
      @(posedge rclk);
      @(negedge rclk);
      mon_en = 1'b1;

      // Idle after reset with nothing to read.
      do_reset();
      for (int c = 0; c < 10; c++) begin
         @(negedge rclk);
         #1;
         check("idle_rd_en", 32'(ram_rd_en), 0);
         check("idle_rptr", 32'(rptr), 0);
         check("idle_valid", 32'(dout_valid), 0);
      end

      // Four preloaded words streamed out back to back.
      @(negedge rclk);
      hold_empty = 1'b0;
      for (int i = 0; i < 4; i++) write_word(8'hA0 + DW'(i));
      for (int i = 0; i < 7; i++) begin
         dout_ready = t2[i].ready;
         #1;
         check("t2_rd_en", 32'(ram_rd_en), 32'(t2[i].rd_en));
         check("t2_valid", 32'(dout_valid), 32'(t2[i].valid));
         if (t2[i].valid) check("t2_dout", 32'(dout), 32'(t2[i].dout));
         check("t2_rptr", 32'(rptr), 32'(t2[i].rptr));
         @(posedge rclk);
         @(negedge rclk);
      end

      // Consumer stalled with eight words available.
      dout_ready = 1'b0;
      for (int i = 0; i < 8; i++) write_word(8'h10 + DW'(i));
      first = 8'h10;
      n_rd  = 0;
      for (int c = 0; c < 10; c++) begin
         #1;
         if (ram_rd_en) n_rd++;
         if (c >= 2) begin
            check("stall_valid", 32'(dout_valid), 1);
            check("stall_dout", 32'(dout), 32'(first));
         end
         @(posedge rclk);
         @(negedge rclk);
      end
      check("stall_reads", 32'(n_rd), 2);
      dout_ready = 1'b1;
      guard      = 0;
      while (exp_q.size() != 0 && guard < 30) begin
         @(posedge rclk);
         @(negedge rclk);
         guard++;
      end
      check("stall_drain", 32'(exp_q.size()), 0);
      @(posedge rclk);
      @(negedge rclk);
      #1;
      check("stall_after_valid", 32'(dout_valid), 0);

      // Twenty words through a 16-entry pointer space.
      @(negedge rclk);
      do_reset();
      @(negedge rclk);
      saw_adr_wrap  = 1'b0;
      saw_rptr_wrap = 1'b0;
      stream(20);
      check("adr_wrap_seen", 32'(saw_adr_wrap), 1);
      check("rptr_wrap_seen", 32'(saw_rptr_wrap), 1);

      // Reset with words buffered and a read in flight, then with the buffer full.
      for (int v = 0; v < 2; v++) begin
         dout_ready = 1'b0;
         for (int i = 0; i < 4; i++) write_word(8'hC0 + DW'(4 * v + i));
         repeat (v == 0 ? 2 : 3) begin
            @(posedge rclk);
            @(negedge rclk);
         end
         do_reset();
         dout_ready = 1'b1;
         for (int c = 0; c < 5; c++) begin
            @(negedge rclk);
            #1;
            check("post_rst_valid", 32'(dout_valid), 0);
            check("post_rst_rd_en", 32'(ram_rd_en), 0);
         end
         @(negedge rclk);
         stream(3);
      end

`ifdef FIFO_RD_WORDCNT_EN
      @(negedge rclk);
      do_reset();
      @(negedge rclk);
      stream(300);
      #1;
      check("rd_count_300", 32'(rd_count), 300);
      @(negedge rclk);
      stream(65536 - 300);
      #1;
      check("rd_count_wrap", 32'(rd_count), 0);
`endif

      repeat (3) @(negedge rclk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
